// File: rtl/spi_cmd_pkg.sv
// Shared constants and types for the SPI command-link initiator.
// Frame layout is {opcode[7:0], payload[31:0]}, shifted MSB first.
package spi_cmd_pkg;

    localparam int FRAME_BITS   = 40;
    localparam int OP_BITS      = 8;
    localparam int DATA_BITS    = 32;
    localparam int TMR_BITS     = 16;
    localparam int BIT_CNT_BITS = 6;

    localparam logic [OP_BITS-1:0] OP_START    = 8'h01;
    localparam logic [OP_BITS-1:0] OP_STOP     = 8'h02;
    localparam logic [OP_BITS-1:0] OP_TON      = 8'h10;
    localparam logic [OP_BITS-1:0] OP_TOFF     = 8'h11;
    localparam logic [OP_BITS-1:0] OP_IP       = 8'h12;
    localparam logic [OP_BITS-1:0] OP_WAVEFORM = 8'h13;
    localparam logic [OP_BITS-1:0] OP_FEEDBACK = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/spi_master_cmd_if.sv
// Command/response handshake plus SPI pins of the command-link initiator.
//   master modport : the initiator (spi_master_cmd)
//   slave  modport : the host logic / link partner driving commands and miso
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command request, accepted on valid & ready
//   rsp_valid/rsp_data                  : one-cycle response pulse with 32 MISO bits
//   busy                                : high from accept until back in IDLE
//   sclk/cs_n/mosi/miso                 : SPI mode 0 pins
interface spi_master_cmd_if;
    import spi_cmd_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [OP_BITS-1:0]   cmd_op;
    logic [DATA_BITS-1:0] cmd_data;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 busy;
    logic                 sclk;
    logic                 cs_n;
    logic                 mosi;
    logic                 miso;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, miso,
        output cmd_ready, rsp_valid, rsp_data, busy, sclk, cs_n, mosi
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, miso,
        input  cmd_ready, rsp_valid, rsp_data, busy, sclk, cs_n, mosi
    );

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV sys_clk cycles per half period, starting low.
//   sys_clk, sys_rst : clock, async active-high reset
//   en               : run; while low the counter and sclk are held cleared
//   sclk             : registered SPI clock
//   rise_stb         : high in the cycle whose closing edge drives sclk 0->1
//   fall_stb         : high in the cycle whose closing edge drives sclk 1->0
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;
    logic          half_done;

    assign half_done = en && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_stb  = half_done && !sclk;
    assign fall_stb  = half_done && sclk;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (half_done) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master_cmd.sv
// SPI mode-0 initiator for the command link: sends {cmd_op, cmd_data} as one
// 40-bit MSB-first frame and returns the last 32 MISO bits of that frame.
//   sys_clk, sys_rst : clock, async active-high reset
//   bus (master)     : command/response handshake and SPI pins
// Parameters: CLK_DIV (sys_clk per SCLK half, >= 2), CS_SETUP, CS_HOLD, CS_IDLE
// (cycles, each >= 1).
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | cs_n low, first bit on mosi, CS_SETUP cycles before clocking
// SHIFT | 40 SCLK periods; miso captured on rise, mosi advanced on fall
// HOLD  | cs_n still low for CS_HOLD cycles after the last fall
// GAP   | cs_n high, CS_IDLE cycles before the next command is accepted
module spi_master_cmd
    import spi_cmd_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    spi_master_cmd_if.master bus
);

    state_t                  state_q, state_d;
    logic [TMR_BITS-1:0]     tmr_q;
    logic [BIT_CNT_BITS-1:0] bit_cnt_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]    rx_q;
    logic [DATA_BITS-1:0]    rsp_data_q;
    logic                    cmd_ready_q;
    logic                    rsp_valid_q;

    logic accept, tmr_done, last_bit;
    logic sclk_en, sclk_w, rise_stb, fall_stb;
    logic cs_n_w, mosi_w, busy_w;

    assign accept   = bus.cmd_valid && cmd_ready_q;
    assign tmr_done = (tmr_q == '0);
    assign last_bit = (bit_cnt_q == '0);

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .en       (sclk_en),
        .sclk     (sclk_w),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)               state_d = ST_SETUP;
            ST_SETUP: if (tmr_done)             state_d = ST_SHIFT;
            ST_SHIFT: if (fall_stb && last_bit) state_d = ST_HOLD;
            ST_HOLD:  if (tmr_done)             state_d = ST_GAP;
            ST_GAP:   if (tmr_done)             state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n_w  = 1'b1;
        mosi_w  = 1'b0;
        sclk_en = 1'b0;
        busy_w  = (state_q != ST_IDLE);
        case (state_q)
            ST_SETUP: begin
                cs_n_w = 1'b0;
                mosi_w = shift_q[FRAME_BITS-1];
            end
            ST_SHIFT: begin
                cs_n_w  = 1'b0;
                mosi_w  = shift_q[FRAME_BITS-1];
                sclk_en = 1'b1;
            end
            ST_HOLD: begin
                cs_n_w = 1'b0;
                mosi_w = shift_q[FRAME_BITS-1];
            end
            default: ;
        endcase
    end

    // Phase timer: loaded with (length - 1) on entry, state advances at zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            tmr_q <= '0;
        end else if (state_d != state_q) begin
            case (state_d)
                ST_SETUP: tmr_q <= TMR_BITS'(CS_SETUP - 1);
                ST_HOLD:  tmr_q <= TMR_BITS'(CS_HOLD - 1);
                ST_GAP:   tmr_q <= TMR_BITS'(CS_IDLE - 1);
                default:  tmr_q <= '0;
            endcase
        end else if (!tmr_done) begin
            tmr_q <= tmr_q - TMR_BITS'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            // Registered so it stays low through reset and rises one edge after.
            cmd_ready_q <= (state_d == ST_IDLE);
            rsp_valid_q <= (state_q == ST_HOLD) && tmr_done;
            if ((state_q == ST_HOLD) && tmr_done) begin
                rsp_data_q <= rx_q;
            end
            if (accept) begin
                shift_q   <= {bus.cmd_op, bus.cmd_data};
                bit_cnt_q <= BIT_CNT_BITS'(FRAME_BITS - 1);
            end else if (state_q == ST_SHIFT) begin
                if (rise_stb) begin
                    // Only the last 32 bits survive; the opcode-phase bits fall off the top.
                    rx_q <= {rx_q[DATA_BITS-2:0], bus.miso};
                end
                // No shift after the final bit so mosi keeps bit 0 through HOLD.
                if (fall_stb && !last_bit) begin
                    shift_q   <= {shift_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_q <= bit_cnt_q - BIT_CNT_BITS'(1);
                end
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.busy      = busy_w;
    assign bus.sclk      = sclk_w;
    assign bus.cs_n      = cs_n_w;
    assign bus.mosi      = mosi_w;

endmodule

// File: tb/tb_spi_master_cmd.sv
module tb_spi_master_cmd;
    import spi_cmd_pkg::*;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_op    = '0;
    logic [31:0] cmd_data  = '0;
    logic        miso      = 1'b0;
    logic        sel       = 1'b0;   // 0: default-parameter DUT, 1: fast DUT

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int cd = 4, su = 2, ho = 2, idl = 4;

    spi_master_cmd_if bus_a ();
    spi_master_cmd_if bus_b ();

    assign bus_a.cmd_valid = cmd_valid & ~sel;
    assign bus_a.cmd_op    = cmd_op;
    assign bus_a.cmd_data  = cmd_data;
    assign bus_a.miso      = miso;
    assign bus_b.cmd_valid = cmd_valid & sel;
    assign bus_b.cmd_op    = cmd_op;
    assign bus_b.cmd_data  = cmd_data;
    assign bus_b.miso      = miso;

    spi_master_cmd #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(4)) u_dut_a (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_a)
    );

    spi_master_cmd #(.CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u_dut_b (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus_b)
    );

    logic        m_sclk, m_cs_n, m_mosi, m_busy, m_cmd_ready, m_rsp_valid;
    logic [31:0] m_rsp_data;
    assign m_sclk      = sel ? bus_b.sclk      : bus_a.sclk;
    assign m_cs_n      = sel ? bus_b.cs_n      : bus_a.cs_n;
    assign m_mosi      = sel ? bus_b.mosi      : bus_a.mosi;
    assign m_busy      = sel ? bus_b.busy      : bus_a.busy;
    assign m_cmd_ready = sel ? bus_b.cmd_ready : bus_a.cmd_ready;
    assign m_rsp_valid = sel ? bus_b.rsp_valid : bus_a.rsp_valid;
    assign m_rsp_data  = sel ? bus_b.rsp_data  : bus_a.rsp_data;

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc = cyc + 1;
    end

    // Observed per-frame results, filled by the link-partner monitor.
    logic [39:0] cap_q[$];
    int          bits_q[$];
    int          low_q[$];
    int          gap_q[$];
    int          fall_q[$];
    logic [31:0] rsp_q[$];
    int          rspcyc_q[$];

    logic [39:0] slave_tx = '0;
    logic [39:0] txw = '0;
    logic [39:0] cap = '0;
    bit prev_cs = 1'b1, prev_sclk = 1'b0, prev_rsp = 1'b0;
    int low_cnt = 0, rise_cyc = 0, mon_bits = 0, last_rise = 0, tx_idx = -1;
    int per_bad = 0, ready_bad = 0, rsp_multi = 0;

    // SPI link partner: shifts slave_tx out on miso (updated after each SCLK
    // fall), captures mosi on each SCLK rise, and times cs_n / rsp_valid.
    initial forever begin
        @(negedge sys_clk);
        if (!m_cs_n && prev_cs) begin
            fall_q.push_back(cyc);
            gap_q.push_back(cyc - rise_cyc);
            low_cnt  = 0;
            mon_bits = 0;
            cap      = '0;
            txw      = slave_tx;
            miso     = txw[39];
            tx_idx   = 38;
        end
        if (!m_cs_n) begin
            low_cnt = low_cnt + 1;
            if (m_cmd_ready || !m_busy) ready_bad = ready_bad + 1;
            if (m_sclk && !prev_sclk) begin
                if (mon_bits > 0 && (cyc - last_rise) != 2 * cd) per_bad = per_bad + 1;
                last_rise = cyc;
                cap       = {cap[38:0], m_mosi};
                mon_bits  = mon_bits + 1;
            end
            if (!m_sclk && prev_sclk && tx_idx >= 0) begin
                miso   = txw[tx_idx];
                tx_idx = tx_idx - 1;
            end
        end
        if (m_cs_n && !prev_cs) begin
            rise_cyc = cyc;
            low_q.push_back(low_cnt);
            cap_q.push_back(cap);
            bits_q.push_back(mon_bits);
        end
        if (m_rsp_valid) begin
            rsp_q.push_back(m_rsp_data);
            rspcyc_q.push_back(cyc);
            if (prev_rsp) rsp_multi = rsp_multi + 1;
        end
        prev_cs   = m_cs_n;
        prev_sclk = m_sclk;
        prev_rsp  = m_rsp_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic clear_q();
        cap_q.delete(); bits_q.delete(); low_q.delete(); gap_q.delete();
        fall_q.delete(); rsp_q.delete(); rspcyc_q.delete();
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] data, input logic [39:0] tx,
                        input bit keep, output int acc);
        int n;
        n        = 0;
        cmd_op   = op;
        cmd_data = data;
        slave_tx = tx;
        cmd_valid = 1'b1;
        while (!m_cmd_ready && n < 2000) begin
            tick();
            n = n + 1;
        end
        chk("accept", m_cmd_ready, 1'b1);
        acc = cyc;
        tick();
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_ready(output int rc);
        int n;
        n = 0;
        while (!m_cmd_ready && n < 2000) begin
            tick();
            n = n + 1;
        end
        rc = cyc;
    endtask

    // Reference: cs_n low for SETUP + 80*CLK_DIV + HOLD cycles starting the
    // cycle after accept, response in the first cs_n-high cycle, ready after
    // CS_IDLE more cycles; MOSI carries {op,data}, rsp_data is the partner's
    // last 32 bits.
    task automatic check_frame(input logic [7:0] op, input logic [31:0] data, input logic [39:0] tx,
                               input int acc, input int rc, input int exp_gap);
        int low, g;
        low = su + 80 * cd + ho;
        chk("frame_seen", (fall_q.size() > 0 && gap_q.size() > 0 && low_q.size() > 0 &&
                           cap_q.size() > 0 && bits_q.size() > 0 && rsp_q.size() > 0 &&
                           rspcyc_q.size() > 0), 1'b1);
        if (fall_q.size() == 0 || gap_q.size() == 0 || low_q.size() == 0 || cap_q.size() == 0 ||
            bits_q.size() == 0 || rsp_q.size() == 0 || rspcyc_q.size() == 0) begin
            clear_q();
            return;
        end
        g = gap_q.pop_front();
        chk("cs_fall_cycle", fall_q.pop_front(), acc + 1);
        chk("cs_low_len",    low_q.pop_front(),  low);
        chk("mosi_frame",    cap_q.pop_front(),  {op, data});
        chk("mosi_bits",     bits_q.pop_front(), 40);
        chk("rsp_data",      rsp_q.pop_front(),  tx[31:0]);
        chk("rsp_cycle",     rspcyc_q.pop_front(), acc + 1 + low);
        if (exp_gap >= 0) chk("cs_gap", g, exp_gap);
        chk("ready_cycle",   rc, acc + 1 + low + idl);
    endtask

    task automatic rand_frame();
        logic [7:0]  op;
        logic [31:0] data;
        logic [39:0] tx;
        int acc, rc;
        op   = 8'($urandom);
        data = $urandom;
        tx   = {8'($urandom), 32'($urandom)};
        send(op, data, tx, 1'b0, acc);
        wait_ready(rc);
        check_frame(op, data, tx, acc, rc, -1);
    endtask

    initial begin
        int acc, rc, n;
        logic [7:0]  ops[3];
        logic [31:0] datas[3];
        logic [39:0] txs[3];
        int accs[3];
        logic [39:0] tx;
        logic [31:0] d;

        // Reset values
        repeat (3) tick();
        chk("rst_cmd_ready", m_cmd_ready, 1'b0);
        chk("rst_cs_n",      m_cs_n,      1'b1);
        chk("rst_sclk",      m_sclk,      1'b0);
        chk("rst_busy",      m_busy,      1'b0);
        chk("rst_rsp_valid", m_rsp_valid, 1'b0);
        chk("rst_mosi",      m_mosi,      1'b0);
        chk("rst_rsp_data",  m_rsp_data,  32'h0);
        sys_rst = 1'b0;
        #1;
        chk("ready_before_edge", m_cmd_ready, 1'b0);
        tick();
        chk("ready_after_rst", m_cmd_ready, 1'b1);

        // Write Ton
        tx = {8'h5A, 32'h1357_9BDF};
        send(OP_TON, 32'h0000_1388, tx, 1'b0, acc);
        chk("busy_after_accept", m_busy, 1'b1);
        wait_ready(rc);
        check_frame(OP_TON, 32'h0000_1388, tx, acc, rc, -1);

        // Feedback read
        tx = {8'($urandom), 32'hABCD_1234};
        send(OP_FEEDBACK, 32'h0, tx, 1'b0, acc);
        wait_ready(rc);
        check_frame(OP_FEEDBACK, 32'h0, tx, acc, rc, -1);

        // Random commands, including unknown opcodes
        repeat (3) rand_frame();

        // cmd_valid pulsed mid-frame is ignored
        tx = {8'($urandom), 32'($urandom)};
        d  = $urandom;
        send(OP_IP, d, tx, 1'b0, acc);
        repeat (50) tick();
        cmd_op    = OP_STOP;
        cmd_data  = $urandom;
        cmd_valid = 1'b1;
        repeat (3) tick();
        cmd_valid = 1'b0;
        wait_ready(rc);
        check_frame(OP_IP, d, tx, acc, rc, -1);
        repeat (20) tick();
        chk("ignored_no_frame", fall_q.size(), 0);

        // Back-to-back with cmd_valid held high
        for (int k = 0; k < 3; k++) begin
            ops[k]   = 8'($urandom);
            datas[k] = $urandom;
            txs[k]   = {8'($urandom), 32'($urandom)};
        end
        for (int k = 0; k < 3; k++) begin
            send(ops[k], datas[k], txs[k], (k < 2), accs[k]);
        end
        wait_ready(rc);
        check_frame(ops[0], datas[0], txs[0], accs[0], accs[1], -1);
        check_frame(ops[1], datas[1], txs[1], accs[1], accs[2], idl + 1);
        check_frame(ops[2], datas[2], txs[2], accs[2], rc, idl + 1);

        // Reset in the middle of a frame
        send(OP_WAVEFORM, $urandom, {8'($urandom), 32'($urandom)}, 1'b0, acc);
        n = 0;
        while (mon_bits < 20 && n < 1000) begin
            tick();
            n = n + 1;
        end
        chk("reached_bit20", (mon_bits >= 20), 1'b1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("abort_cs_n",  m_cs_n,      1'b1);
        chk("abort_sclk",  m_sclk,      1'b0);
        chk("abort_busy",  m_busy,      1'b0);
        chk("abort_ready", m_cmd_ready, 1'b0);
        repeat (3) tick();
        chk("abort_no_rsp", rsp_q.size(), 0);
        sys_rst = 1'b0;
        #1;
        chk("abort_ready_low", m_cmd_ready, 1'b0);
        tick();
        chk("abort_ready_back", m_cmd_ready, 1'b1);
        clear_q();
        rand_frame();

        // Fast parameter set: CLK_DIV=2, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1
        sel = 1'b1;
        cd = 2; su = 1; ho = 1; idl = 1;
        tick();
        repeat (3) rand_frame();

        chk("sclk_period_err", per_bad,   0);
        chk("ready_in_frame",  ready_bad, 0);
        chk("rsp_pulse_len",   rsp_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
